pwm_duty_seq: RTL

//  Sequencer that moves the pwm_gen duty cycle to a commanded step (0..MAX_STEP, 10%/step).

---
 rtl/pwm_duty_seq_pkg.sv | 26 ++
 rtl/pwm_duty_seq_if.sv | 31 +++
 rtl/pwm_duty_seq_timer.sv | 25 ++
 rtl/pwm_duty_seq.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pwm_duty_seq_pkg.sv
// Shared types and defaults for the pwm_gen duty-step sequencer.
// Imported by the interface and the top level.
package pwm_duty_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } seq_state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } seq_dir_t;

    localparam int DEF_MAX_STEP  = 10;
    localparam int DEF_INIT_STEP = 5;

    // Requested steps beyond the pwm_gen ceiling are pinned to it.
    function automatic int clamp_step(input int step, input int max_step);
        return (step > max_step) ? max_step : step;
    endfunction

endpackage

// File: rtl/pwm_duty_seq_if.sv
// Command/status bundle between control logic and the duty sequencer.
// The master drives commands; the slave (the sequencer) drives pulses and status.
interface pwm_duty_seq_if
    import pwm_duty_seq_pkg::*;
#(
    parameter int DW = $clog2(DEF_MAX_STEP + 1)
);
    logic          cmd_valid;
    logic [DW-1:0] cmd_target;
    logic          cmd_ready;
    logic          abort;
    logic          increase_duty;
    logic          decrease_duty;
    logic [DW-1:0] duty_est;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          cmd_err;

    modport master (
        output cmd_valid, cmd_target, abort,
        input  cmd_ready, increase_duty, decrease_duty, duty_est,
               busy, done, aborted, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_target, abort,
        output cmd_ready, increase_duty, decrease_duty, duty_est,
               busy, done, aborted, cmd_err
    );
endinterface

// File: rtl/pwm_duty_seq_timer.sv
// Loadable down-counter that times both the pulse-high and gap-low phases.
// A load of L makes zero assert L cycles later.
module pwm_duty_seq_timer #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);
    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/pwm_duty_seq.sv
// Steps the pwm_gen duty cycle toward a commanded value with spaced inc/dec pulses,
// tracking the resulting duty step locally.
module pwm_duty_seq
    import pwm_duty_seq_pkg::*;
#(
    parameter int MAX_STEP  = DEF_MAX_STEP,
    parameter int INIT_STEP = DEF_INIT_STEP,
    parameter int PULSE_LEN = 1,
    parameter int GAP_LEN   = 2
) (
    input  logic          clk,
    input  logic          rst,
    pwm_duty_seq_if.slave bus
);
    localparam int DW = $clog2(MAX_STEP + 1);
    localparam int TW = $clog2(((PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN) + 1);
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_LEN - 1);
    localparam logic [DW-1:0] MAX_Q      = DW'(MAX_STEP);
    localparam logic [DW-1:0] INIT_Q     = DW'(INIT_STEP);

    seq_state_t    state;
    seq_dir_t      dir;
    logic [DW-1:0] tgt;
    logic [DW-1:0] duty_q;
    logic          abort_pend;
    logic          abort_now;
    logic          ready_q, inc_q, dec_q, busy_q, done_q, aborted_q, err_q;
    logic          timer_load, timer_zero;
    logic [TW-1:0] timer_val;

    assign abort_now = abort_pend | bus.abort;

    // Reload the timer on every edge that leaves a timed phase (or starts the first pulse).
    always_comb begin
        timer_load = 1'b0;
        timer_val  = PULSE_LOAD;
        case (state)
            ST_DECIDE: timer_load = 1'b1;
            ST_PULSE: begin
                timer_load = timer_zero;
                timer_val  = GAP_LOAD;
            end
            ST_GAP:    timer_load = timer_zero;
            default:   timer_load = 1'b0;
        endcase
    end

    pwm_duty_seq_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            dir        <= DIR_UP;
            tgt        <= INIT_Q;
            duty_q     <= INIT_Q;
            abort_pend <= 1'b0;
            ready_q    <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
            if (bus.abort && state != ST_IDLE && state != ST_DONE) begin
                abort_pend <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid && ready_q) begin
                        tgt     <= DW'(clamp_step(int'(bus.cmd_target), MAX_STEP));
                        err_q   <= (int'(bus.cmd_target) > MAX_STEP);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= ST_DECIDE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_DECIDE: begin
                    if (tgt == duty_q || abort_now) begin
                        done_q    <= 1'b1;
                        aborted_q <= abort_now;
                        state     <= ST_DONE;
                    end else begin
                        dir   <= (tgt > duty_q) ? DIR_UP : DIR_DN;
                        inc_q <= (tgt > duty_q);
                        dec_q <= (tgt < duty_q);
                        state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (timer_zero) begin
                        inc_q <= 1'b0;
                        dec_q <= 1'b0;
                        if (dir == DIR_UP && duty_q != MAX_Q) begin
                            duty_q <= duty_q + 1'b1;
                        end else if (dir == DIR_DN && duty_q != '0) begin
                            duty_q <= duty_q - 1'b1;
                        end
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timer_zero) begin
                        if (duty_q == tgt || abort_now) begin
                            done_q    <= 1'b1;
                            aborted_q <= abort_now;
                            state     <= ST_DONE;
                        end else begin
                            inc_q <= (dir == DIR_UP);
                            dec_q <= (dir == DIR_DN);
                            state <= ST_PULSE;
                        end
                    end
                end
                ST_DONE: begin
                    abort_pend <= 1'b0;
                    busy_q     <= 1'b0;
                    ready_q    <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready     = ready_q;
    assign bus.increase_duty = inc_q;
    assign bus.decrease_duty = dec_q;
    assign bus.duty_est      = duty_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.aborted       = aborted_q;
    assign bus.cmd_err       = err_q;
endmodule
